// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit with alignment/bounds checks and sub-word read-modify-write
module lsu_mem_ctrl #(
  parameter int unsigned MEM_BYTES    = 64,
  parameter int unsigned PROTECT_BASE = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic        ram_read_en,
  output logic        ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fault_q, fault_d;
  logic        ill, mis, acc;
  logic [1:0]  fault_c;
  logic [31:0] ext, merged;
  // classify the incoming request; illegal beats misaligned beats access
  always_comb begin
    ill     = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    mis     = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    acc     = req_addr < PROTECT_BASE || req_addr > MEM_BYTES - 4;
    fault_c = ill ? 2'd3 : mis ? 2'd1 : acc ? 2'd2 : 2'd0;
  end
  // load extension and sub-word merge of the word the RAM returns during READ
  always_comb begin
    ext    = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & ram_read_data[7]}}, ram_read_data[7:0]} :
             f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & ram_read_data[15]}}, ram_read_data[15:0]} :
             ram_read_data;
    merged = f3_q[0] ? {ram_read_data[31:16], wdata_q[15:0]} : {ram_read_data[31:8], wdata_q[7:0]};
  end
  // next-state and next-register computation
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        fault_d = fault_c;
        state_d = fault_c != 2'd0 ? RESP : (req_we && req_funct3[1:0] == 2'd2) ? WRITE : READ;
      end
      READ: begin
        wdata_d = we_q ? merged : wdata_q;
        rdata_d = we_q ? '0 : ext;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end
  assign req_ready      = state_q == IDLE;
  assign rsp_valid      = state_q == RESP;
  assign rsp_rdata      = rsp_valid ? rdata_q : '0;
  assign rsp_fault      = rsp_valid ? fault_q : '0;
  assign ram_read_en    = state_q == READ;
  assign ram_write_en   = state_q == WRITE && rst_n;
  assign ram_addr       = (state_q == READ || state_q == WRITE) ? addr_q : '0;
  assign ram_write_data = state_q == WRITE ? wdata_q : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: transaction-level reference model plus directed and randomized stimulus for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, ram_read_data;
  logic        req_ready, rsp_valid, ram_read_en, ram_write_en;
  logic [31:0] rsp_rdata, ram_addr, ram_write_data;
  logic [1:0]  rsp_fault;
  logic [7:0]  mem [64];
  logic [7:0]  ref_mem [64];
  int vectors = 0, miscompares = 0, rd_cnt = 0, wr_cnt = 0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .ram_read_en(ram_read_en),
    .ram_write_en(ram_write_en), .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM: combinational read, commit on the rising edge
  always_comb
    ram_read_data = (ram_read_en && ram_addr <= 60) ?
      {mem[ram_addr[5:0] + 6'd3], mem[ram_addr[5:0] + 6'd2], mem[ram_addr[5:0] + 6'd1], mem[ram_addr[5:0]]} :
      32'hA5A5A5A5;

  always @(posedge clk) begin
    if (ram_write_en && ram_addr <= 60)
      for (int k = 0; k < 4; k++) mem[ram_addr[5:0] + 6'(k)] <= ram_write_data[8*k +: 8];
    if (ram_read_en) rd_cnt++;
    if (ram_write_en) wr_cnt++;
  end

  // transaction-level reference model
  bit started = 0, busy = 0, m_we;
  bit [31:0] m_a, m_rdata, m_wdata;
  bit [1:0] m_fault;
  int cnt, lat, m_sz;

  function automatic bit [31:0] ref_word(input bit [31:0] a);
    return a <= 60 ? {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]} : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1;
      busy = 0;
    end else if (busy) begin
      if (cnt >= lat) begin
        if (rsp_ready) busy = 0;
      end else begin
        if (m_we && m_fault == 0 && cnt == lat - 1)
          for (int k = 0; k < 4; k++) ref_mem[m_a + k] = m_wdata[8*k +: 8];
        cnt++;
      end
    end else if (req_valid && started) begin
      bit ill, mis, acc;
      bit [31:0] w, mask, v;
      busy = 1;
      cnt = 1;
      m_we = req_we;
      m_a = req_addr;
      m_sz = req_funct3[1:0] == 0 ? 1 : req_funct3[1:0] == 1 ? 2 : 4;
      ill = req_we ? req_funct3 > 2 : req_funct3 inside {3'd3, 3'd6, 3'd7};
      mis = (m_sz == 2 && m_a % 2 != 0) || (m_sz == 4 && m_a % 4 != 0);
      acc = m_a < 24 || m_a > 60;
      m_fault = ill ? 2'd3 : mis ? 2'd1 : acc ? 2'd2 : 2'd0;
      w = ref_word(m_a);
      mask = m_sz == 1 ? 32'hFF : m_sz == 2 ? 32'hFFFF : 32'hFFFFFFFF;
      m_rdata = 0;
      m_wdata = (w & ~mask) | (req_wdata & mask);
      if (m_fault != 0) lat = 1;
      else if (!m_we) begin
        lat = 2;
        v = w & mask;
        if (!req_funct3[2] && m_sz < 4 && v >= (mask + 1) / 2) v = v | ~mask;
        m_rdata = v;
      end else lat = m_sz == 4 ? 2 : 3;
    end
  end

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) if (started) begin
    bit ev, rd, wu;
    ev = busy && cnt >= lat;
    rd = busy && m_fault == 0 && cnt == 1 && !(m_we && m_sz == 4);
    wu = busy && m_fault == 0 && m_we && cnt == lat - 1;
    chk("req_ready", req_ready, !busy);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_fault", rsp_fault, ev ? m_fault : 2'd0);
    chk("rsp_rdata", rsp_rdata, ev ? m_rdata : 32'h0);
    chk("ram_read_en", ram_read_en, rd);
    chk("ram_write_en", ram_write_en, wu && rst_n);
    chk("ram_addr", ram_addr, (rd || wu) ? m_a : 32'h0);
    chk("ram_write_data", ram_write_data, wu ? m_wdata : 32'h0);
  end

  task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                     input bit [1:0] ef, input bit [31:0] er, input int el, input int hold,
                     input int estrb, input int ewr);
    int r0, w0, n;
    r0 = rd_cnt;
    w0 = wr_cnt;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1;
    rsp_ready = hold == 0;
    @(posedge clk); #1 req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, el);
    chk("fault", rsp_fault, ef);
    chk("rdata", rsp_rdata, er);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("ready_after", req_ready, 1);
    chk("strobes", (rd_cnt - r0) + (wr_cnt - w0), estrb);
    chk("write_pulses", wr_cnt - w0, ewr);
  endtask

  initial begin
    logic [31:0] old;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    {mem[27], mem[26], mem[25], mem[24]} = 32'hFF007F80;
    {ref_mem[27], ref_mem[26], ref_mem[25], ref_mem[24]} = 32'hFF007F80;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_read_en", ram_read_en, 0);
    rst_n = 1;
    @(posedge clk); #1;
    txn(0, 3'b000, 24, 0, 2'b00, 32'hFFFFFF80, 2, 0, 1, 0);
    txn(0, 3'b100, 24, 0, 2'b00, 32'h00000080, 2, 0, 1, 0);
    txn(0, 3'b001, 24, 0, 2'b00, 32'h00007F80, 2, 0, 1, 0);
    txn(0, 3'b010, 24, 0, 2'b00, 32'hFF007F80, 2, 0, 1, 0);
    txn(1, 3'b000, 24, 32'h12345678, 2'b00, 0, 3, 0, 2, 1);
    txn(0, 3'b010, 24, 0, 2'b00, 32'hFF007F78, 2, 0, 1, 0);
    txn(1, 3'b001, 24, 32'h0000ABCD, 2'b00, 0, 3, 0, 2, 1);
    txn(0, 3'b010, 24, 0, 2'b00, 32'hFF00ABCD, 2, 0, 1, 0);
    txn(0, 3'b010, 26, 0, 2'b01, 0, 1, 0, 0, 0);
    txn(0, 3'b001, 25, 0, 2'b01, 0, 1, 0, 0, 0);
    txn(1, 3'b010, 20, 32'h11111111, 2'b10, 0, 1, 0, 0, 0);
    txn(0, 3'b000, 61, 0, 2'b10, 0, 1, 0, 0, 0);
    txn(0, 3'b011, 24, 0, 2'b11, 0, 1, 0, 0, 0);
    txn(1, 3'b111, 61, 32'h22222222, 2'b11, 0, 1, 0, 0, 0);
    txn(0, 3'b000, 23, 0, 2'b10, 0, 1, 0, 0, 0);
    txn(0, 3'b010, 24, 0, 2'b00, 32'hFF00ABCD, 2, 5, 1, 0);
    old = {mem[43], mem[42], mem[41], mem[40]};
    req_we = 1; req_funct3 = 3'b010; req_addr = 40; req_wdata = ~old;
    req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    chk("in_write", ram_write_en, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_mem", {mem[43], mem[42], mem[41], mem[40]}, old);
    rst_n = 1;
    @(posedge clk); #1;
    txn(1, 3'b010, 60, 32'hDEADBEEF, 2'b00, 0, 2, 0, 1, 1);
    txn(0, 3'b010, 60, 0, 2'b00, 32'hDEADBEEF, 2, 0, 1, 0);
    for (int c = 0; c < 3000; c++) begin
      req_valid = $urandom % 2 == 0;
      req_we = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr = $urandom_range(16, 66);
      req_wdata = $urandom;
      rsp_ready = $urandom % 4 != 0;
      rst_n = $urandom % 300 != 0;
      @(posedge clk); #1;
    end
    req_valid = 0;
    rst_n = 1;
    rsp_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
